// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader.
// Contents: FSM state encoding, error codes, default memory geometry and the
// byte step between consecutive 32-bit words.
package imem_loader_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StVerify,
        StDone
    } ld_state_e;

    localparam logic [1:0] ErrNone   = 2'd0;
    localparam logic [1:0] ErrCount  = 2'd1;
    localparam logic [1:0] ErrAddr   = 2'd2;
    localparam logic [1:0] ErrVerify = 2'd3;

    // Highest valid byte address and the word count that exactly fills memory.
    localparam int unsigned MemTopDefault   = 600;
    localparam int unsigned MaxWordsDefault = MemTopDefault / 4 + 1;

    // Byte distance between consecutive instruction words.
    localparam int unsigned WordStep = 4;

endpackage

// File: rtl/ld_checksum.sv
// 32-bit wrapping accumulator used for the write and readback checksums.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-low reset, clears the sum
//   clr  - synchronous clear (wins over en)
//   en   - add din into the sum this cycle
//   din  - value to accumulate
//   sum  - current accumulated value
module ld_checksum (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic [31:0] din,
    output logic [31:0] sum
);

    logic [31:0] sum_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum_q <= '0;
        end else if (clr) begin
            sum_q <= '0;
        end else if (en) begin
            sum_q <= sum_q + din;
        end
    end

    assign sum = sum_q;

endmodule

// File: rtl/imem_loader.sv
// Streams a program into instruction memory, reads it back and checks a
// checksum, holding the processor stalled until a load has been verified.
// Ports:
//   clk, rst            - clock and asynchronous active-low reset
//   start               - one-cycle load request, only honoured in idle
//   base_adr, word_cnt  - byte address of first word and number of words
//   s_valid/s_data      - incoming word stream; s_ready marks acceptance
//   imem_we/adr/wdata   - instruction memory write port (adr also drives readback)
//   imem_rdata          - combinational read data at imem_adr
//   cpu_hold            - 1 stalls the processor
//   busy, done          - not idle / one-cycle success pulse
//   err, err_code       - sticky error flag and its cause
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned MEM_TOP       = MemTopDefault,
    parameter int unsigned MAX_WORDS     = MaxWordsDefault,
    parameter bit          HOLD_AT_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] base_adr,
    input  logic [15:0] word_cnt,
    input  logic        s_valid,
    input  logic [31:0] s_data,
    output logic        s_ready,
    output logic        imem_we,
    output logic [31:0] imem_adr,
    output logic [31:0] imem_wdata,
    input  logic [31:0] imem_rdata,
    output logic        cpu_hold,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code
);

    ld_state_e   state_q;
    logic [31:0] cur_adr_q;
    logic [31:0] base_q;
    logic [15:0] cnt_q;
    logic [15:0] remaining_q;
    logic        err_q;
    logic [1:0]  err_code_q;
    logic        hold_q;

    logic [31:0] wsum;
    logic [31:0] rsum;
    logic [31:0] rsum_final;
    logic [32:0] last_adr;
    logic        cnt_bad;
    logic        adr_bad;
    logic        accept;
    logic        xfer;
    logic        in_verify;

    // Last word address computed one bit wider so a huge base cannot wrap into range.
    assign last_adr = {1'b0, base_adr} + {15'd0, word_cnt - 16'd1, 2'b00};
    assign cnt_bad  = (word_cnt == 16'd0) || ({16'd0, word_cnt} > MAX_WORDS);
    assign adr_bad  = (base_adr[1:0] != 2'b00) || (last_adr > {1'b0, MEM_TOP});
    assign accept   = (state_q == StIdle) && start && !cnt_bad && !adr_bad;

    assign xfer      = (state_q == StLoad) && s_valid;
    assign in_verify = (state_q == StVerify);

    // Readback sum including the word presented this cycle.
    assign rsum_final = rsum + imem_rdata;

    ld_checksum u_wsum (
        .clk (clk),
        .rst (rst),
        .clr (accept),
        .en  (xfer),
        .din (s_data),
        .sum (wsum)
    );

    ld_checksum u_rsum (
        .clk (clk),
        .rst (rst),
        .clr (accept),
        .en  (in_verify),
        .din (imem_rdata),
        .sum (rsum)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            cur_adr_q   <= '0;
            base_q      <= '0;
            cnt_q       <= '0;
            remaining_q <= '0;
            err_q       <= 1'b0;
            err_code_q  <= ErrNone;
            hold_q      <= HOLD_AT_RESET;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        if (cnt_bad) begin
                            err_q      <= 1'b1;
                            err_code_q <= ErrCount;
                        end else if (adr_bad) begin
                            err_q      <= 1'b1;
                            err_code_q <= ErrAddr;
                        end else begin
                            base_q      <= base_adr;
                            cnt_q       <= word_cnt;
                            cur_adr_q   <= base_adr;
                            remaining_q <= word_cnt;
                            err_q       <= 1'b0;
                            err_code_q  <= ErrNone;
                            hold_q      <= 1'b1;
                            state_q     <= StLoad;
                        end
                    end
                end
                StLoad: begin
                    if (s_valid) begin
                        if (remaining_q == 16'd1) begin
                            // Rewind for readback over the same range.
                            cur_adr_q   <= base_q;
                            remaining_q <= cnt_q;
                            state_q     <= StVerify;
                        end else begin
                            cur_adr_q   <= cur_adr_q + WordStep;
                            remaining_q <= remaining_q - 16'd1;
                        end
                    end
                end
                StVerify: begin
                    cur_adr_q   <= cur_adr_q + WordStep;
                    remaining_q <= remaining_q - 16'd1;
                    if (remaining_q == 16'd1) begin
                        if (rsum_final == wsum) begin
                            state_q <= StDone;
                        end else begin
                            // Processor stays held: memory contents are suspect.
                            err_q      <= 1'b1;
                            err_code_q <= ErrVerify;
                            state_q    <= StIdle;
                        end
                    end
                end
                StDone: begin
                    hold_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign s_ready    = (state_q == StLoad);
    assign imem_we    = xfer;
    assign imem_adr   = cur_adr_q;
    assign imem_wdata = xfer ? s_data : '0;
    assign cpu_hold   = hold_q;
    assign busy       = (state_q != StIdle);
    assign done       = (state_q == StDone);
    assign err        = err_q;
    assign err_code   = err_code_q;

endmodule
